// File: rtl/shared_reg_arb_pkg.sv
// Shared types, defaults and helpers for the shared-register round-robin arbiter.
// The optional hold-grant feature of the top is enabled by defining SHARED_REG_LOCK_EN.

`ifndef SHARED_REG_ARB_IDX_W
`define SHARED_REG_ARB_IDX_W(n) shared_reg_arb_pkg::clog2(n)
`endif

package shared_reg_arb_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 1;

    // Index width for n requesters; never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned k = 1; k < 32; k++) begin
            if ((32'd1 << r) < n) begin
                r = k + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request scanning from ptr upward with wrap.

module rr_pick
    import shared_reg_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned IDX_W = clog2(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_c,
    output logic [IDX_W-1:0] idx_c,
    output logic             any_c
);

    logic [IDX_W:0] pos;

    // Walk the rotated request vector from ptr and stop at the first set bit.
    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        pos   = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            pos = (IDX_W+1)'(ptr_i) + (IDX_W+1)'(k);
            if (pos >= (IDX_W+1)'(N_REQ)) begin
                pos = pos - (IDX_W+1)'(N_REQ);
            end
            if (!any_c && req_i[pos[IDX_W-1:0]]) begin
                any_c = 1'b1;
                idx_c = pos[IDX_W-1:0];
            end
        end
        if (any_c) begin
            gnt_c[idx_c] = 1'b1;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter owning one WIDTH-bit register shared by N_REQ requesters.
// Define SHARED_REG_LOCK_EN to let a granted requester hold the grant with lock[i].

module shared_reg_arbiter
    import shared_reg_arb_pkg::*;
#(
    parameter int unsigned      N_REQ   = DEF_N_REQ,
    parameter int unsigned      WIDTH   = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ*WIDTH-1:0]               din,
    input  logic [N_REQ-1:0]                     lock,
    output logic [N_REQ-1:0]                     gnt,
    output logic [WIDTH-1:0]                     q,
    output logic                                 q_valid,
    output logic [`SHARED_REG_ARB_IDX_W(N_REQ)-1:0] q_id
);

    localparam int unsigned IDX_W = clog2(N_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [IDX_W-1:0] id_q, id_d;
    logic             valid_q, valid_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             xfer;
    logic [WIDTH-1:0] din_sel;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_c (pick_gnt),
        .idx_c (pick_idx),
        .any_c (pick_any)
    );

    // Reset suppresses the grant, so any transfer offered that cycle is dropped.
    assign gnt     = rst ? '0 : pick_gnt;
    assign xfer    = pick_any & ~rst;
    assign din_sel = din[pick_idx*WIDTH +: WIDTH];

`ifndef SHARED_REG_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    // Next pointer and register contents.
    always_comb begin
        ptr_d   = ptr_q;
        q_d     = q_q;
        id_d    = id_q;
        valid_d = 1'b0;
        if (xfer) begin
            valid_d = 1'b1;
            q_d     = din_sel;
            id_d    = pick_idx;
            if (pick_idx == IDX_W'(N_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + IDX_W'(1);
            end
`ifdef SHARED_REG_LOCK_EN
            // Winner asking to keep the register: leave priority on it.
            if (lock[pick_idx] && req[pick_idx]) begin
                ptr_d = pick_idx;
            end
`endif
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            q_q     <= RST_VAL;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            q_q     <= q_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    assign q       = q_q;
    assign q_id    = id_q;
    assign q_valid = valid_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, RST_VAL=0).

module tb_shared_reg_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic         v;
        logic [W-1:0] q;
        logic [1:0]   id;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   din;
    logic [N-1:0]     lock;
    logic [N-1:0]     gnt;
    logic [W-1:0]     q;
    logic             q_valid;
    logic [1:0]       q_id;

    exp_t exp_q[$];
    int   total;
    int   bad;

    shared_reg_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .RST_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .lock    (lock),
        .gnt     (gnt),
        .q       (q),
        .q_valid (q_valid),
        .q_id    (q_id)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One clock of stimulus: check gnt before the edge, queue the expected register state after it.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*W-1:0] d,
                        input logic [N-1:0] lk, input logic [N-1:0] egnt,
                        input logic ev, input logic [W-1:0] eq, input logic [1:0] eid,
                        input string name);
        exp_t e;
        rst  = r;
        req  = rq;
        din  = d;
        lock = lk;
        @(negedge clk);
        total++;
        if (gnt !== egnt) begin
            bad++;
            $display("FAIL %s gnt: got %b want %b", name, gnt, egnt);
        end
        @(posedge clk);
        e.v  = ev;
        e.q  = eq;
        e.id = eid;
        exp_q.push_back(e);
        #1;
    endtask

    // Monitor: every cycle compare the registered outputs against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (q_valid !== e.v) begin
                    bad++;
                    $display("FAIL q_valid: got %b want %b", q_valid, e.v);
                end
                total++;
                if (q !== e.q) begin
                    bad++;
                    $display("FAIL q: got %h want %h", q, e.q);
                end
                total++;
                if (q_id !== e.id) begin
                    bad++;
                    $display("FAIL q_id: got %0d want %0d", q_id, e.id);
                end
            end else if (q_valid === 1'b1) begin
                total++;
                bad++;
                $display("FAIL unexpected q_valid: got 1 want 0 (q=%h)", q);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    localparam logic [N*W-1:0] DS = 32'h13121110;

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        req   = '0;
        din   = '0;
        lock  = '0;
        @(posedge clk);
        #1;

        // Reset with all requesting: no grant, register at reset value.
        for (int i = 0; i < 3; i++) step(1, 4'b1111, DS, 0, 4'b0000, 0, 8'h00, 0, "rst_hold");

        // Single transfer, then hold.
        step(0, 4'b0001, 32'h000000A5, 0, 4'b0001, 1, 8'hA5, 0, "single");
        step(0, 4'b0000, 32'h000000A5, 0, 4'b0000, 0, 8'hA5, 0, "idle_hold");

        // All requesting: strict rotation from 0.
        step(1, 4'b0000, DS, 0, 4'b0000, 0, 8'h00, 0, "rst3");
        for (int r = 0; r < 2; r++) begin
            step(0, 4'b1111, DS, 0, 4'b0001, 1, 8'h10, 0, "rot0");
            step(0, 4'b1111, DS, 0, 4'b0010, 1, 8'h11, 1, "rot1");
            step(0, 4'b1111, DS, 0, 4'b0100, 1, 8'h12, 2, "rot2");
            step(0, 4'b1111, DS, 0, 4'b1000, 1, 8'h13, 3, "rot3");
        end

        // Reset mid-stream discards the offered transfer and restarts at 0.
        step(0, 4'b1111, DS, 0, 4'b0001, 1, 8'h10, 0, "pre_rst0");
        step(0, 4'b1111, DS, 0, 4'b0010, 1, 8'h11, 1, "pre_rst1");
        step(1, 4'b1111, DS, 0, 4'b0000, 0, 8'h00, 0, "mid_rst");
        step(0, 4'b1111, DS, 0, 4'b0001, 1, 8'h10, 0, "post_rst0");
        step(0, 4'b1111, DS, 0, 4'b0010, 1, 8'h11, 1, "post_rst1");

        // Sparse requests with pointer wrap 3 -> 0.
        step(1, 4'b0000, DS, 0, 4'b0000, 0, 8'h00, 0, "rst4");
        step(0, 4'b1010, DS, 0, 4'b0010, 1, 8'h11, 1, "sparse_a");
        step(0, 4'b1010, DS, 0, 4'b1000, 1, 8'h13, 3, "sparse_b");
        step(0, 4'b1010, DS, 0, 4'b0010, 1, 8'h11, 1, "sparse_c");
        step(0, 4'b1010, DS, 0, 4'b1000, 1, 8'h13, 3, "sparse_d");
        // ptr=0 and requester 0 absent: next set bit wins at once.
        step(0, 4'b0100, DS, 0, 4'b0100, 1, 8'h12, 2, "skip_ptr");
        step(0, 4'b0001, DS, 0, 4'b0001, 1, 8'h10, 0, "wrap_pick");

        // Lock behaviour on requester 2.
        step(1, 4'b0000, DS, 0, 4'b0000, 0, 8'h00, 0, "rst6");
        step(0, 4'b1111, DS, 0, 4'b0001, 1, 8'h10, 0, "lk_pre0");
        step(0, 4'b1111, DS, 0, 4'b0010, 1, 8'h11, 1, "lk_pre1");
`ifdef SHARED_REG_LOCK_EN
        step(0, 4'b1111, DS, 4'b0100, 4'b0100, 1, 8'h12, 2, "lk_1");
        step(0, 4'b1111, DS, 4'b0100, 4'b0100, 1, 8'h12, 2, "lk_2");
        step(0, 4'b1111, DS, 4'b0100, 4'b0100, 1, 8'h12, 2, "lk_3");
        step(0, 4'b1111, DS, 4'b0000, 4'b0100, 1, 8'h12, 2, "lk_rel");
        step(0, 4'b1111, DS, 4'b0001, 4'b1000, 1, 8'h13, 3, "lk_other");
        step(0, 4'b1111, DS, 4'b0000, 4'b0001, 1, 8'h10, 0, "lk_after");
`else
        step(0, 4'b1111, DS, 4'b0100, 4'b0100, 1, 8'h12, 2, "nolk_1");
        step(0, 4'b1111, DS, 4'b0100, 4'b1000, 1, 8'h13, 3, "nolk_2");
        step(0, 4'b1111, DS, 4'b0100, 4'b0001, 1, 8'h10, 0, "nolk_3");
        step(0, 4'b1111, DS, 4'b0000, 4'b0010, 1, 8'h11, 1, "nolk_4");
        step(0, 4'b1111, DS, 4'b0001, 4'b0100, 1, 8'h12, 2, "nolk_5");
        step(0, 4'b1111, DS, 4'b0000, 4'b1000, 1, 8'h13, 3, "nolk_6");
`endif

        // Drain and make sure every expectation was consumed.
        req  = '0;
        lock = '0;
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
